// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter holds bit indices 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: retires one difference bit per clock, LSB first, through a
// registered borrow, and assembles the parallel result with a done pulse.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             diff_bit,
    output logic             bit_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
    logic [CW-1:0]    cnt;
    logic             br, d, br_nx, last;

    full_subtractor u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (br),
        .d   (d),
        .bout(br_nx)
    );

    assign busy   = (state == SHIFT);
    assign last   = (state == SHIFT) && (cnt == LAST);
    assign res_nx = {d, res_sr[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff_bit  <= 1'b0;
            bit_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            if (state == IDLE && start) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                diff_bit  <= d;
                bit_valid <= 1'b1;
                res_sr    <= res_nx;
                a_sr      <= a_sr >> 1;
                b_sr      <= b_sr >> 1;
                br        <= br_nx;
                cnt       <= cnt + 1'b1;
                // Final bit: publish the assembled result and borrow-out together.
                if (last) begin
                    diff <= res_nx;
                    bout <= br_nx;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 directed/random and WIDTH=2 exhaustive.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, dbit8, bval8, bout8, done8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, dbit2, bval2, bout2, done2;
    logic [1:0] a2, b2, diff2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .diff_bit(dbit8), .bit_valid(bval8), .diff(diff8),
        .bout(bout8), .done(done8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .diff_bit(dbit2), .bit_valid(bval2), .diff(diff2),
        .bout(bout2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one WIDTH=8 operation from the current cycle; returns in the done cycle.
    // With poke set, start is pulsed again in busy cycles 3 and 5.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit poke);
        int          ref_d;
        logic [7:0]  exp_d;
        logic        exp_bo;
        ref_d  = int'(a) - int'(b) - int'(bin);
        exp_d  = 8'(ref_d);
        exp_bo = (int'(a) < int'(b) + int'(bin));
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("bit_valid", 32'(bval8), 32'd1);
            chk("diff_bit", 32'(dbit8), 32'(exp_d[k]));
            chk("done", 32'(done8), (k == 7) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy8), (k == 7) ? 32'd0 : 32'd1);
            start8 = poke && (k == 1 || k == 3);
        end
        start8 = 1'b0;
        chk("diff", 32'(diff8), 32'(exp_d));
        chk("bout", 32'(bout8), 32'(exp_bo));
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        int         ref_d;
        logic [1:0] exp_d;
        ref_d = int'(a) - int'(b) - int'(bin);
        exp_d = 2'(ref_d);
        start2 = 1'b1; a2 = a; b2 = b; bin2 = bin;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(posedge clk); #1;
        chk("w2_done_early", 32'(done2), 32'd0);
        chk("w2_bit0", 32'(dbit2), 32'(exp_d[0]));
        @(posedge clk); #1;
        chk("w2_done", 32'(done2), 32'd1);
        chk("w2_diff", 32'(diff2), 32'(exp_d));
        chk("w2_bout", 32'(bout2), (int'(a) < int'(b) + int'(bin)) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_bval", 32'(bval8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 1'b0);
        op8(8'h10, 8'h10, 1'b1, 1'b0);
        // Ignored starts mid-operation, then back-to-back start in the done cycle.
        op8(8'hC3, 8'h47, 1'b1, 1'b1);
        op8(8'h21, 8'h9E, 1'b0, 1'b0);

        // Reset sampled on the edge retiring bit 4.
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h12; bin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_bval", 32'(bval8), 32'd0);
        chk("mid_rst_diff", 32'(diff8), 32'd0);
        chk("mid_rst_bout", 32'(bout8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", 32'(done8), 32'd0);
        end
        op8(8'hFF, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

        for (int v = 0; v < 32; v++)
            op2(2'(v >> 3), 2'(v >> 1), 1'(v));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
